// File: rtl/mult_sequencer_if.sv
// Handshake and result bundle between the pipeline controller and the
// sequential signed multiplier.
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             readReq;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, opA, opB, readReq,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, opA, opB, readReq,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add signed multiplier: WIDTH CALC steps on magnitudes, then a
// SIGN step that applies the sign and commits {hi,lo}.
//
// state | meaning
// IDLE  | waiting for start, hi/lo hold last committed product
// CALC  | one shift-add step per edge on the unsigned magnitudes
// SIGN  | apply sign, commit hi/lo, pulse done
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mult_sequencer_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_legal;

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_mag_a = bus.opA[WIDTH-1] ? -bus.opA : bus.opA;
    assign w_mag_b = bus.opB[WIDTH-1] ? -bus.opB : bus.opB;

    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_result   = r_neg ? -r_acc : r_acc;
    assign w_legal    = (r_state == IDLE) || (r_state == CALC) || (r_state == SIGN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_state == SIGN) begin
                {r_hi, r_lo} <= w_result;
                r_done       <= 1'b1;
            end

            // A new start wins over stepping or finishing; in SIGN the old result still commits above.
            if (bus.start && w_legal) begin
                r_mcand  <= w_mag_a;
                r_mplier <= w_mag_b;
                r_neg    <= bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1];
                r_acc    <= '0;
                r_cnt    <= '0;
                r_state  <= CALC;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_busy <= 1'b0;
                    end
                    CALC: begin
                        r_acc    <= w_acc_next;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state <= SIGN;
                        end
                    end
                    SIGN: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = bus.readReq & r_busy;
endmodule
